// File: rtl/mips_pkg.sv
// mips_pkg: shared widths, fetch defaults and the fetch-entry type
package mips_pkg;
  localparam int XLEN = 32;
  localparam int INSTR_W = 32;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int PC_STEP = 4;
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    pc;
  } fetch_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: synchronous FIFO with flush and a registered head
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, rd_nxt;
  logic do_pop;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign do_pop = pop && !empty;
  assign rd_nxt = rd_ptr + AW'(do_pop);
  always_ff @(posedge clock)
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      rdata <= '0;
    end else begin
      if (push) mem[wr_ptr] <= wdata;
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_nxt;
      count <= count + CW'(push) - CW'(do_pop);
      // when the pop drains the stored entries the incoming word becomes the head
      rdata <= (count == CW'(do_pop)) ? wdata : mem[rd_nxt];
    end
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: fetch PC owner, credit-limited imem requester and tagged instruction buffer
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter logic [mips_pkg::XLEN-1:0] RESET_PC = mips_pkg::DEFAULT_RESET_PC,
  parameter int PC_STEP = mips_pkg::PC_STEP
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         redirect_valid,
  input  logic [mips_pkg::XLEN-1:0]    redirect_pc,
  output logic                         imem_req,
  output logic [mips_pkg::XLEN-1:0]    imem_addr,
  input  logic [mips_pkg::INSTR_W-1:0] imem_rdata,
  output logic                         instr_valid,
  input  logic                         instr_ready,
  output logic [mips_pkg::INSTR_W-1:0] instr,
  output logic [mips_pkg::XLEN-1:0]    instr_pc
);
  import mips_pkg::*;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [0:0] RUN = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;
  logic [0:0] state;
  logic inflight, inflight_eff, pop, rsp, full, empty;
  logic [XLEN-1:0] fetch_pc, req_pc;
  logic [CW-1:0] count;
  logic [CW:0] occ;
  fetch_entry_t head;
  // the cycle after a redirect can never have a response outstanding
  assign inflight_eff = state == RUN && inflight;
  assign pop = instr_valid && instr_ready && !redirect_valid;
  assign rsp = inflight_eff && !redirect_valid && !reset;
  assign occ = (CW+1)'(count) + (CW+1)'(inflight_eff) - (CW+1)'(pop);
  assign imem_req = !reset && !redirect_valid && occ < (CW+1)'(DEPTH);
  assign imem_addr = fetch_pc;
  assign instr_valid = !empty;
  assign instr = head.instr;
  assign instr_pc = head.pc;
  always_ff @(posedge clock)
    if (reset) begin
      state <= RUN;
      inflight <= 1'b0;
      fetch_pc <= RESET_PC;
      req_pc <= '0;
    end else begin
      state <= redirect_valid ? FLUSH : RUN;
      inflight <= imem_req;
      req_pc <= imem_req ? fetch_pc : req_pc;
      fetch_pc <= redirect_valid ? redirect_pc : imem_req ? fetch_pc + XLEN'(PC_STEP) : fetch_pc;
    end
  sync_fifo #(.DEPTH(DEPTH), .WIDTH($bits(fetch_entry_t))) u_fifo (
    .clock(clock),
    .reset(reset),
    .flush(redirect_valid),
    .push(rsp && (!full || pop)),
    .pop(pop),
    .wdata({imem_rdata, req_pc}),
    .rdata(head),
    .count(count),
    .empty(empty),
    .full(full)
  );
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed plus random stimulus against a queue-based fetch model
module tb_fetch_queue;
  import mips_pkg::*;
  localparam int DEPTH = 4;
  localparam logic [31:0] RST_PC = 32'h0;
  logic clock = 0;
  logic reset, redirect_valid, instr_ready, imem_req, instr_valid;
  logic [31:0] redirect_pc, imem_addr, imem_rdata, instr, instr_pc;
  int checks = 0, errors = 0;
  fetch_entry_t q[$];
  logic [31:0] mfpc = RST_PC, ipc = 0;
  logic infl = 0;
  logic [31:0] reqs[$], got[$];

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RST_PC), .PC_STEP(4)) dut (
    .clock(clock), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {16'hA5A5, a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rst, input logic redir, input logic [31:0] rpc, input logic rdy);
    logic exp_req, exp_valid, pop;
    int occ;
    @(negedge clock);
    reset = rst;
    redirect_valid = redir;
    redirect_pc = rpc;
    instr_ready = rdy;
    imem_rdata = infl ? mem_fn(ipc) : $urandom;
    #1;
    exp_valid = q.size() > 0;
    pop = exp_valid && rdy && !redir && !rst;
    occ = q.size() + int'(infl) - int'(pop);
    exp_req = !rst && !redir && occ < DEPTH;
    chk("req", {31'b0, imem_req}, {31'b0, exp_req});
    chk("addr", imem_addr, mfpc);
    chk("valid", {31'b0, instr_valid}, {31'b0, exp_valid});
    if (exp_valid) begin
      chk("instr", instr, q[0].instr);
      chk("instr_pc", instr_pc, q[0].pc);
    end
    chk("overflow", {31'b0, dut.rsp && dut.full && !dut.pop}, 32'h0);
    if (imem_req) reqs.push_back(imem_addr);
    if (pop) got.push_back(instr_pc);
    if (rst || redir) begin
      q.delete();
      infl = 0;
      mfpc = rst ? RST_PC : rpc;
    end else begin
      if (pop) void'(q.pop_front());
      if (infl) q.push_back('{instr: mem_fn(ipc), pc: ipc});
      infl = exp_req;
      if (exp_req) begin
        ipc = mfpc;
        mfpc = mfpc + 32'd4;
      end
    end
  endtask

  initial begin
    int bad;
    logic r_rst, r_redir;
    logic [31:0] r_pc;
    reset = 1; redirect_valid = 0; redirect_pc = 0; instr_ready = 0; imem_rdata = 0;
    // sequential streaming after reset
    step(1, 0, 0, 1);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    reqs.delete(); got.delete();
    repeat (12) step(0, 0, 0, 1);
    chk("t1_nreq", reqs.size(), 12);
    chk("t1_ngot", got.size(), 10);
    chk("t1_req3", reqs[3], 32'hC);
    chk("t1_got0", got[0], 32'h0);
    chk("t1_got2", got[2], 32'h8);
    // consumer stalled: credit limit then drain
    step(1, 0, 0, 0);
    reqs.delete(); got.delete();
    repeat (8) step(0, 0, 0, 0);
    chk("t2_nreq", reqs.size(), 4);
    chk("t2_req3", reqs[3], 32'hC);
    chk("t2_hold_valid", {31'b0, instr_valid}, 32'h1);
    chk("t2_hold_pc", instr_pc, 32'h0);
    reqs.delete();
    repeat (6) step(0, 0, 0, 1);
    chk("t2_ngot", got.size(), 6);
    chk("t2_got0", got[0], 32'h0);
    chk("t2_got1", got[1], 32'h4);
    chk("t2_got2", got[2], 32'h8);
    chk("t2_got3", got[3], 32'hC);
    chk("t2_resume", reqs[0], 32'h10);
    // redirect with three buffered entries
    step(1, 0, 0, 0);
    repeat (4) step(0, 0, 0, 0);
    step(0, 1, 32'h40, 0);
    got.delete(); reqs.delete();
    step(0, 0, 0, 1);
    chk("t3_valid", {31'b0, instr_valid}, 32'h0);
    chk("t3_addr", reqs[0], 32'h40);
    repeat (6) step(0, 0, 0, 1);
    chk("t3_first", got[0], 32'h40);
    bad = 0;
    foreach (got[i]) if (got[i] < 32'h40) bad++;
    chk("t3_old_stream", bad, 0);
    // redirect in the cycle the 0x8 response returns
    step(1, 0, 0, 1);
    repeat (3) step(0, 0, 0, 1);
    step(0, 1, 32'h100, 1);
    got.delete();
    repeat (5) step(0, 0, 0, 1);
    chk("t4_first", got[0], 32'h100);
    // reset pulse with FIFO full
    step(1, 0, 0, 0);
    repeat (8) step(0, 0, 0, 0);
    chk("t5_full", {31'b0, dut.full}, 32'h1);
    step(1, 0, 0, 0);
    reqs.delete();
    step(0, 0, 0, 1);
    chk("t5_valid", {31'b0, instr_valid}, 32'h0);
    chk("t5_instr", instr, 32'h0);
    chk("t5_instr_pc", instr_pc, 32'h0);
    chk("t5_restart", reqs[0], RST_PC);
    // address wrap
    step(0, 1, 32'hFFFF_FFF8, 1);
    reqs.delete(); got.delete();
    repeat (8) step(0, 0, 0, 1);
    chk("t6_req0", reqs[0], 32'hFFFF_FFF8);
    chk("t6_req1", reqs[1], 32'hFFFF_FFFC);
    chk("t6_req2", reqs[2], 32'h0);
    chk("t6_req3", reqs[3], 32'h4);
    chk("t6_got0", got[0], 32'hFFFF_FFF8);
    chk("t6_got1", got[1], 32'hFFFF_FFFC);
    chk("t6_got2", got[2], 32'h0);
    chk("t6_got3", got[3], 32'h4);
    // random traffic
    repeat (400) begin
      r_rst = $urandom_range(0, 63) == 0;
      r_redir = !r_rst && $urandom_range(0, 15) == 0;
      r_pc = $urandom_range(0, 3) == 0 ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
      step(r_rst, r_redir, r_pc, $urandom_range(0, 3) != 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
